// File: rtl/register_file_mp_pkg.sv
// Shared constants for the multi-port register file.
// Holds the default geometry used by register_file_mp and its write arbiter.
package register_file_mp_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned N_RD_DEF   = 4;
  localparam int unsigned N_WR_DEF   = 2;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Per-register write arbiter for register_file_mp.
// For every register it picks the highest-indexed enabled write port that targets it and
// reports whether two or more enabled ports hit the same register.
// Ports:
//   we_i        per-port write enable
//   waddr_i     packed write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata_i     packed write data, port k at [k*DATA_W +: DATA_W]
//   reg_we_o    per-register write enable
//   reg_wdata_o packed per-register write data, register r at [r*DATA_W +: DATA_W]
//   conflict_o  raw (unregistered) multi-port same-address flag
module regfile_wr_arbiter
  import register_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned N_WR     = N_WR_DEF,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned N_REG   = 2 ** ADDR_W
) (
  input  logic [N_WR-1:0]         we_i,
  input  logic [N_WR*ADDR_W-1:0]  waddr_i,
  input  logic [N_WR*DATA_W-1:0]  wdata_i,
  output logic [N_REG-1:0]        reg_we_o,
  output logic [N_REG*DATA_W-1:0] reg_wdata_o,
  output logic                    conflict_o
);

  always_comb begin
    reg_we_o    = '0;
    reg_wdata_o = '0;
    conflict_o  = 1'b0;
    for (int r = 0; r < N_REG; r++) begin
      // A hardwired zero register never takes writes, so it cannot conflict either.
      if (!(ZERO_REG && (r == 0))) begin
        // Ascending scan: a later (higher) port overwrites the earlier selection.
        for (int k = 0; k < N_WR; k++) begin
          if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
            if (reg_we_o[r]) begin
              conflict_o = 1'b1;
            end
            reg_we_o[r]                  = 1'b1;
            reg_wdata_o[r*DATA_W +: DATA_W] = wdata_i[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: N_RD combinational read ports, N_WR write ports, optional
// hardwired-zero register 0, optional write-to-read bypass and a synchronous whole-file clear.
// Ports:
//   clk_i         rising-edge clock
//   arst_i        asynchronous active-high reset
//   clr_i         synchronous clear of every register, overrides writes
//   we_i          per-port write enable
//   waddr_i       packed write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wdata_i       packed write data, port k at [k*DATA_W +: DATA_W]
//   raddr_i       packed read addresses, port j at [j*ADDR_W +: ADDR_W]
//   rdata_o       packed read data, port j at [j*DATA_W +: DATA_W]
//   wr_conflict_o registered: multiple enabled ports hit one register on the previous edge
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned N_RD     = N_RD_DEF,
  parameter int unsigned N_WR     = N_WR_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   clr_i,
  input  logic [N_WR-1:0]        we_i,
  input  logic [N_WR*ADDR_W-1:0] waddr_i,
  input  logic [N_WR*DATA_W-1:0] wdata_i,
  input  logic [N_RD*ADDR_W-1:0] raddr_i,
  output logic [N_RD*DATA_W-1:0] rdata_o,
  output logic                   wr_conflict_o
);

  localparam int unsigned N_REG = 2 ** ADDR_W;

  logic [DATA_W-1:0]        regs_q [N_REG];
  logic [DATA_W-1:0]        regs_d [N_REG];
  logic [N_REG-1:0]         reg_we;
  logic [N_REG*DATA_W-1:0]  reg_wdata;
  logic                     conflict_raw;
  logic                     wr_conflict_q, wr_conflict_d;
  logic [ADDR_W-1:0]        rd_addr;

  regfile_wr_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .N_WR     (N_WR),
    .ZERO_REG (ZERO_REG)
  ) u_wr_arbiter (
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .reg_we_o    (reg_we),
    .reg_wdata_o (reg_wdata),
    .conflict_o  (conflict_raw)
  );

  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      regs_d[r] = regs_q[r];
      if (clr_i) begin
        regs_d[r] = '0;
      end else if (reg_we[r]) begin
        regs_d[r] = reg_wdata[r*DATA_W +: DATA_W];
      end
    end
    wr_conflict_d = conflict_raw & ~clr_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int r = 0; r < N_REG; r++) begin
        regs_q[r] <= '0;
      end
      wr_conflict_q <= 1'b0;
    end else begin
      for (int r = 0; r < N_REG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict_o = wr_conflict_q;

  // Read path priority (lowest to highest): stored value, bypass, zero register, reset.
  // Bypass deliberately ignores clr_i so a same-cycle read still sees the write data.
  always_comb begin
    rdata_o = '0;
    rd_addr = '0;
    for (int j = 0; j < N_RD; j++) begin
      rd_addr = raddr_i[j*ADDR_W +: ADDR_W];
      rdata_o[j*DATA_W +: DATA_W] = regs_q[rd_addr];
      if (BYPASS) begin
        for (int k = 0; k < N_WR; k++) begin
          if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] == rd_addr)) begin
            rdata_o[j*DATA_W +: DATA_W] = wdata_i[k*DATA_W +: DATA_W];
          end
        end
      end
      if ((ZERO_REG && (rd_addr == '0)) || arst_i) begin
        rdata_o[j*DATA_W +: DATA_W] = '0;
      end
    end
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, dual-read register file used by the CPU datapath.
- Provides N_RD combinational read ports and N_WR write ports, with an optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a synchronous whole-file clear.
- Targets the dual-issue pipeline variant: two writebacks per cycle, four operand reads.

Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 5: address width; N_REG = 2**ADDR_W registers.
- N_RD, 4: number of read ports (≥1).
- N_WR, 2: number of write ports (≥1).
- ZERO_REG, 1: when 1, register 0 always reads 0 and ignores writes.
- BYPASS, 1: when 1, a read of an address being written this cycle returns the incoming write data.

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous clear of all registers.
- we  in  N_WR  per-port write enable.
- waddr  in  N_WR*ADDR_W  write addresses; port k at bits [k*ADDR_W +: ADDR_W].
- wdata  in  N_WR*DATA_W  write data; port k at bits [k*DATA_W +: DATA_W].
- raddr  in  N_RD*ADDR_W  read addresses; port j at bits [j*ADDR_W +: ADDR_W].
- rdata  out  N_RD*DATA_W  read data; port j at bits [j*DATA_W +: DATA_W].
- wr_conflict  out  1  registered flag: two or more enabled write ports targeted the same register in the previous cycle.

Behaviour:
- Reset: arst high clears every register and wr_conflict to 0 immediately, independent of clk. Reads during reset return 0. The first write is accepted on the first rising edge after arst deasserts.
- Storage: N_REG x DATA_W flops. Next state is computed combinationally and registered on posedge clk.
- Write: on posedge clk, for each k with we[k]=1, reg[waddr_k] takes wdata_k. Latency is 1 cycle (visible on rdata the cycle after) unless bypassed.
- Write conflict: when several enabled ports hit the same address, the highest port index wins. wr_conflict is set to 1 on that edge and reads 0 on the next edge with no conflict.
- ZERO_REG=1 rules:
  - Writes to address 0 are dropped.
  - rdata for raddr=0 is always 0.
  - Writes to address 0 do not count as conflicts.
- Clear: clr=1 on posedge clk sets all registers to 0 and overrides all writes in that cycle. wr_conflict is 0 after a clr cycle.
- Read: rdata is combinational from raddr, with zero cycles of latency.
- Bypass with BYPASS=1:
  - If any enabled write port targets raddr_j in the current cycle, rdata_j = wdata of the highest such port.
  - clr=1 does not suppress the bypass; the current-cycle read still returns write data.
  - The zero register takes precedence over the bypass.
- BYPASS=0: rdata returns the stored value only, i.e. the old value during a same-cycle write.
- All read ports are independent. Any number may address the same register.
- Widths: no arithmetic. Out-of-range addresses cannot occur because N_REG = 2**ADDR_W.

Decomposition:
- Shared package holds the default constants and the packed-slice helper width constants: DATA_W_DEF=16, ADDR_W_DEF=5, N_RD_DEF=4, N_WR_DEF=2.
- One natural sub-module, regfile_wr_arbiter: per-register combinational priority select over N_WR ports, producing a write-enable and data per register plus the raw conflict signal.
- The read muxes and bypass logic stay in the top module.

Test Plan:
1. Reset: assert arst mid-simulation with registers holding 0xBEEF. All rdata read 0x0000 immediately and wr_conflict=0; after release, write r3=0x1234 via port 0, and raddr0=3 returns 0x1234 the next cycle.
2. Dual write: port0 writes r5=0x00AA and port1 writes r6=0x0055 in the same cycle. The next cycle reads r5=0x00AA and r6=0x0055, and wr_conflict=0.
3. Conflict: both ports write r7, port0=0x1111 and port1=0x2222. r7 reads 0x2222 and wr_conflict=1 for exactly one cycle.
4. Bypass with BYPASS=1: port1 writes r9=0xCAFE while raddr2=9 in the same cycle, so rdata2=0xCAFE that cycle. With BYPASS=0, rdata2 returns the old value 0x0000.
5. Zero register with ZERO_REG=1: port0 writes r0=0xFFFF. rdata for raddr=0 stays 0x0000 both in the same cycle and the next cycle, and wr_conflict=0.
6. Clear: registers hold nonzero values; assert clr together with a port0 write r4=0x7777. The next cycle all reads, including r4, return 0x0000.
